// File: rtl/cache_pkg.sv
// Shared data-cache definitions: refill FSM states and AXI/line constants.
`default_nettype none

package cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_AR    = 3'd1,
    ST_RECV  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } refill_state_e;

  localparam int          LINE_WORDS     = 8;
  localparam int          OFFSET_BITS    = 5;
  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [1:0]  AXI_BURST_WRAP = 2'b10;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;

endpackage

`default_nettype wire

// File: rtl/refill_line_buffer.sv
// 8-word line assembly register file: one indexed word write per cycle, flat line read.
`default_nettype none

module refill_line_buffer
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             we_i,
  input  logic [2:0]                       idx_i,
  input  logic [DATA_WIDTH-1:0]            wdata_i,
  output logic [DATA_WIDTH*LINE_WORDS-1:0] line_o
);

  logic [DATA_WIDTH-1:0] mem_q [LINE_WORDS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LINE_WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  for (genvar g = 0; g < LINE_WORDS; g++) begin : g_flat
    assign line_o[g*DATA_WIDTH +: DATA_WIDTH] = mem_q[g];
  end

endmodule

`default_nettype wire

// File: rtl/dcache_refill_unit.sv
// Data-cache line-fill engine: one 8-beat AXI4 read burst -> single-cycle full-line bank write.
// Optional CRITICAL_WORD_FIRST_EN: WRAP burst starting at the missed word.
`default_nettype none

module dcache_refill_unit
  import cache_pkg::*;
#(
  parameter int         ADDR_WIDTH = 10,
  parameter int         DATA_WIDTH = 32,
  parameter logic [3:0] AXI_ID     = 4'd1
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             miss_valid,
  input  logic [31:0]                      miss_addr,
  output logic                             miss_ready,
  output logic                             arvalid,
  input  logic                             arready,
  output logic [31:0]                      araddr,
  output logic [7:0]                       arlen,
  output logic [2:0]                       arsize,
  output logic [1:0]                       arburst,
  output logic [3:0]                       arid,
  input  logic                             rvalid,
  input  logic [DATA_WIDTH-1:0]            rdata,
  input  logic                             rlast,
  input  logic [1:0]                       rresp,
  output logic                             rready,
  output logic                             fill_we,
  output logic [ADDR_WIDTH-1:0]            fill_waddr,
  output logic [DATA_WIDTH*LINE_WORDS-1:0] fill_din_all,
  output logic                             crit_valid,
  output logic [DATA_WIDTH-1:0]            crit_data,
  output logic                             refill_done,
  output logic                             refill_err
);

`ifdef CRITICAL_WORD_FIRST_EN
  localparam bit          CWF          = 1'b1;
  localparam logic [31:0] ARADDR_MASK  = 32'hFFFF_FFFC;
  localparam logic [1:0]  BURST_TYPE   = AXI_BURST_WRAP;
`else
  localparam bit          CWF          = 1'b0;
  localparam logic [31:0] ARADDR_MASK  = 32'hFFFF_FFE0;
  localparam logic [1:0]  BURST_TYPE   = AXI_BURST_INCR;
`endif

  refill_state_e state_q, state_d;

  logic [31:0]           addr_q, addr_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [3:0]            beats_q, beats_d;
  logic                  err_q, err_d;
  logic                  crit_valid_q, crit_valid_d;
  logic [DATA_WIDTH-1:0] crit_data_q, crit_data_d;
  logic                  buf_we;
  logic                  beat;
  logic                  accept;
  logic [2:0]            crit_idx;

  assign beat     = rvalid && rready;
  assign accept   = beat && !beats_q[3];
  assign crit_idx = addr_q[4:2];

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (miss_valid) state_d = ST_AR;
      ST_AR:    if (arready) state_d = ST_RECV;
      ST_RECV:  if (beat && rlast) state_d = ST_WRITE;
      ST_WRITE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    miss_ready  = 1'b0;
    arvalid     = 1'b0;
    rready      = 1'b0;
    fill_we     = 1'b0;
    refill_done = 1'b0;
    case (state_q)
      ST_IDLE:  miss_ready  = 1'b1;
      ST_AR:    arvalid     = 1'b1;
      ST_RECV:  rready      = 1'b1;
      ST_WRITE: fill_we     = 1'b1;
      ST_DONE:  refill_done = 1'b1;
      default:  ;
    endcase
  end

  // Beats past the eighth are swallowed so a runaway burst cannot overwrite the line.
  always_comb begin
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    beats_d      = beats_q;
    err_d        = err_q;
    crit_valid_d = 1'b0;
    crit_data_d  = crit_data_q;
    buf_we       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (miss_valid) begin
          addr_d = miss_addr;
          err_d  = 1'b0;
        end
      end
      ST_AR: begin
        if (arready) begin
          cnt_d   = CWF ? crit_idx : 3'd0;
          beats_d = 4'd0;
        end
      end
      ST_RECV: begin
        if (beat) begin
          if (rresp != AXI_RESP_OKAY) err_d = 1'b1;
          if (accept) begin
            buf_we  = 1'b1;
            cnt_d   = cnt_q + 3'd1;
            beats_d = beats_q + 4'd1;
            if (cnt_q == crit_idx) begin
              crit_valid_d = 1'b1;
              crit_data_d  = rdata;
            end
          end else begin
            err_d = 1'b1;
          end
          if (rlast && beats_q != 4'd7) err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q       <= '0;
      cnt_q        <= '0;
      beats_q      <= '0;
      err_q        <= 1'b0;
      crit_valid_q <= 1'b0;
      crit_data_q  <= '0;
    end else begin
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      beats_q      <= beats_d;
      err_q        <= err_d;
      crit_valid_q <= crit_valid_d;
      crit_data_q  <= crit_data_d;
    end
  end

  refill_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_line_buffer (
    .clk     (clk),
    .rst_n   (resetn),
    .we_i    (buf_we),
    .idx_i   (cnt_q),
    .wdata_i (rdata),
    .line_o  (fill_din_all)
  );

  assign araddr     = addr_q & ARADDR_MASK;
  assign arlen      = 8'd7;
  assign arsize     = 3'b010;
  assign arburst    = BURST_TYPE;
  assign arid       = AXI_ID;
  assign fill_waddr = {addr_q[ADDR_WIDTH+1:OFFSET_BITS], 3'b000};
  assign crit_valid = crit_valid_q;
  assign crit_data  = crit_data_q;
  assign refill_err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_dcache_refill_unit.sv
// Directed self-checking bench for dcache_refill_unit with a simple AXI read slave.
`default_nettype none

module tb_dcache_refill_unit;

`ifdef CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         resetn;
  logic         miss_valid;
  logic [31:0]  miss_addr;
  logic         miss_ready;
  logic         arvalid;
  logic         arready;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic [3:0]   arid;
  logic         rvalid;
  logic [31:0]  rdata;
  logic         rlast;
  logic [1:0]   rresp;
  logic         rready;
  logic         fill_we;
  logic [9:0]   fill_waddr;
  logic [255:0] fill_din_all;
  logic         crit_valid;
  logic [31:0]  crit_data;
  logic         refill_done;
  logic         refill_err;

  dcache_refill_unit dut (
    .clk          (clk),
    .resetn       (resetn),
    .miss_valid   (miss_valid),
    .miss_addr    (miss_addr),
    .miss_ready   (miss_ready),
    .arvalid      (arvalid),
    .arready      (arready),
    .araddr       (araddr),
    .arlen        (arlen),
    .arsize       (arsize),
    .arburst      (arburst),
    .arid         (arid),
    .rvalid       (rvalid),
    .rdata        (rdata),
    .rlast        (rlast),
    .rresp        (rresp),
    .rready       (rready),
    .fill_we      (fill_we),
    .fill_waddr   (fill_waddr),
    .fill_din_all (fill_din_all),
    .crit_valid   (crit_valid),
    .crit_data    (crit_data),
    .refill_done  (refill_done),
    .refill_err   (refill_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_buf [8];

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] exp_line();
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = exp_buf[k];
    return l;
  endfunction

  // One complete refill against a bench-side slave; expected line tracked in exp_buf.
  task automatic run_refill(input logic [31:0] addr, input logic [9:0] exp_waddr,
                            input int ar_delay, input int max_gap, input int err_beat,
                            input int nbeats, input logic [31:0] base);
    int       start, word, gap;
    logic [2:0]  crit;
    logic [31:0] exp_ar, d;
    bit       err;
    crit   = addr[4:2];
    start  = CWF ? int'(crit) : 0;
    err    = (nbeats != 8);
    exp_ar = CWF ? {addr[31:2], 2'b00} : {addr[31:5], 5'b00000};
    check("miss_ready", miss_ready, 1'b1);
    miss_valid = 1'b1;
    miss_addr  = addr;
    step();
    miss_valid = 1'b0;
    check("arvalid", arvalid, 1'b1);
    check("araddr", araddr, exp_ar);
    check("arburst", arburst, CWF ? 2'b10 : 2'b01);
    check("arlen", arlen, 8'd7);
    check("arsize", arsize, 3'b010);
    check("arid", arid, 4'd1);
    check("err_clear", refill_err, 1'b0);
    for (int k = 0; k < ar_delay; k++) begin
      step();
      check("arvalid_hold", arvalid, 1'b1);
      check("araddr_hold", araddr, exp_ar);
    end
    arready = 1'b1;
    step();
    arready = 1'b0;
    check("rready", rready, 1'b1);
    check("arvalid_drop", arvalid, 1'b0);
    for (int i = 0; i < nbeats; i++) begin
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      for (int g = 0; g < gap; g++) step();
      word   = (start + i) % 8;
      d      = (i < 8) ? base + word : 32'hDEAD_0000 + i;
      rvalid = 1'b1;
      rdata  = d;
      rresp  = (i == err_beat) ? 2'b10 : 2'b00;
      rlast  = (i == nbeats - 1);
      if (i == err_beat) err = 1'b1;
      step();
      rvalid = 1'b0;
      rlast  = 1'b0;
      rresp  = 2'b00;
      if (i < 8) exp_buf[word] = d;
      check("crit_valid", crit_valid, (i < 8) && (word == int'(crit)));
      if (i < 8 && word == int'(crit)) check("crit_data", crit_data, d);
    end
    check("fill_we", fill_we, 1'b1);
    check("fill_waddr", fill_waddr, exp_waddr);
    check("fill_din_all", fill_din_all, exp_line());
    check("done_early", refill_done, 1'b0);
    step();
    check("refill_done", refill_done, 1'b1);
    check("fill_we_drop", fill_we, 1'b0);
    check("refill_err", refill_err, err);
    step();
    check("done_pulse", refill_done, 1'b0);
    check("back_idle", miss_ready, 1'b1);
    check("err_sticky", refill_err, err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn     = 1'b0;
    miss_valid = 1'b0;
    miss_addr  = '0;
    arready    = 1'b0;
    rvalid     = 1'b0;
    rdata      = '0;
    rlast      = 1'b0;
    rresp      = 2'b00;
    for (int k = 0; k < 8; k++) exp_buf[k] = '0;
    #13;
    check("rst_miss_ready", miss_ready, 1'b1);
    check("rst_arvalid", arvalid, 1'b0);
    check("rst_rready", rready, 1'b0);
    check("rst_fill_we", fill_we, 1'b0);
    check("rst_line", fill_din_all, '0);
    check("rst_waddr", fill_waddr, 10'h000);
    check("rst_crit", {crit_valid, crit_data}, '0);
    check("rst_done_err", {refill_done, refill_err}, 2'b00);
    resetn = 1'b1;
    step();

    // Zero-wait baseline
    run_refill(32'h0000_1234, 10'h088, 0, 0, -1, 8, 32'hA0);
    check("line_a_ref", fill_din_all, {32'hA7, 32'hA6, 32'hA5, 32'hA4, 32'hA3, 32'hA2, 32'hA1, 32'hA0});
    // AR backpressure and R gaps: same line contents
    run_refill(32'h0000_1234, 10'h088, 5, 2, -1, 8, 32'hA0);
    check("line_a_slow", fill_din_all, {32'hA7, 32'hA6, 32'hA5, 32'hA4, 32'hA3, 32'hA2, 32'hA1, 32'hA0});
    // SLVERR on beat 3
    run_refill(32'h0000_2048, 10'h010, 0, 0, 3, 8, 32'hC0);
    // Early rlast on beat 4; stale words remain from the previous fill
    run_refill(32'h0000_1234, 10'h088, 0, 0, -1, 4, 32'hB0);
    // Nine beats: the ninth is discarded
    run_refill(32'h0000_0FFC, 10'h3F8, 1, 1, -1, 9, 32'hE0);

    // Reset in the middle of a burst
    miss_valid = 1'b1;
    miss_addr  = 32'h0000_1234;
    step();
    miss_valid = 1'b0;
    arready = 1'b1;
    step();
    arready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rvalid = 1'b1;
      rdata  = 32'h5500 + i;
      step();
    end
    #2;
    resetn = 1'b0;
    rvalid = 1'b0;
    #1;
    check("mid_rst_ctrl", {arvalid, rready, fill_we, crit_valid, refill_done, refill_err}, 6'b0);
    check("mid_rst_line", fill_din_all, '0);
    check("mid_rst_data", {fill_waddr, crit_data}, '0);
    for (int k = 0; k < 8; k++) exp_buf[k] = '0;
    step();
    resetn = 1'b1;
    step();
    run_refill(32'h0000_0FFC, 10'h3F8, 0, 0, -1, 8, 32'hD0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dcache_refill_unit.md
Name: dcache_refill_unit

Overview:
- Line-fill engine feeding the data-cache way bank (the 8-word, byte-write BRAM bank).
- On a miss it issues one AXI4 read burst of 8 x 32-bit words and assembles them into a 256-bit line.
- It then writes the whole line in one cycle through the bank's refill path: hit_write=1, we=1, din_all.
- It forwards the missed word to the load pipeline and signals completion to the cache FSM.

Parameters:
- ADDR_WIDTH, 10, bank word-address width; line index = waddr[ADDR_WIDTH-1:3].
- DATA_WIDTH, 32, word width; line = DATA_WIDTH*8 bits.
- AXI_ID, 4'd1, constant ARID driven on every request.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- miss_valid  in  1  refill request from cache FSM.
- miss_addr  in  32  physical byte address of the missed access.
- miss_ready  out  1  high only in IDLE.
- arvalid  out  1  AXI AR valid.
- arready  in  1  AXI AR ready.
- araddr  out  32  burst start address.
- arlen  out  8  constant 8'd7.
- arsize  out  3  constant 3'b010.
- arburst  out  2  INCR (2'b01), or WRAP (2'b10) under the option.
- arid  out  4  AXI_ID.
- rvalid  in  1  AXI R valid.
- rdata  in  32  AXI R data.
- rlast  in  1  AXI R last beat.
- rresp  in  2  AXI R response.
- rready  out  1  AXI R ready.
- fill_we  out  1  bank write enable; also drives hit_write.
- fill_waddr  out  ADDR_WIDTH  line base word address, low 3 bits zero.
- fill_din_all  out  DATA_WIDTH*8  assembled line, word i at bits [32i+31:32i].
- crit_valid  out  1  one-cycle pulse: missed word available.
- crit_data  out  32  missed word.
- refill_done  out  1  one-cycle pulse after the line is written.
- refill_err  out  1  sticky for the refill; set by any rresp != OKAY.

Behaviour:
- Reset (async, resetn=0):
  - State IDLE; beat counter 0.
  - Outputs: arvalid, rready, fill_we, crit_valid, refill_done, refill_err = 0; line buffer, fill_waddr, crit_data = 0.
- States: IDLE, AR, RECV, WRITE, DONE.
- IDLE:
  - miss_ready=1.
  - On miss_valid, latch miss_addr; line base = {miss_addr[31:5],5'b0}; go to AR next cycle.
  - Clear refill_err.
- AR:
  - arvalid=1 with araddr held stable until arready.
  - On the handshake, go to RECV; beat counter = starting word (0 for INCR).
- RECV:
  - rready=1.
  - Each rvalid&rready beat writes rdata into buffer word [counter] and increments the counter mod 8 (wrap 7->0).
  - When the beat's word index equals miss_addr[4:2]: crit_valid=1 and crit_data=rdata in the following cycle (registered).
  - rlast with a handshake moves to WRITE.
  - rlast arriving before 8 beats: still move to WRITE and set refill_err; unreceived words keep stale buffer contents.
  - More than 8 beats without rlast: beats after the 8th are accepted and discarded, refill_err set.
- WRITE: exactly one cycle.
  - fill_we=1, fill_waddr=miss_addr[ADDR_WIDTH+1:5]<<3, fill_din_all=buffer.
  - The bank sees we=1, hit_write=1, store=0, so all 32 byte-enables are set.
- DONE: refill_done=1 for one cycle, then IDLE.
- Latency, zero-wait AXI:
  - miss accept -> arvalid: 1 cycle.
  - AR handshake -> first rready: 1 cycle.
  - last beat -> fill_we: 1 cycle.
  - fill_we -> refill_done: 1 cycle.
- miss_valid outside IDLE is ignored; the request is not queued.
- rvalid outside RECV is not accepted (rready=0).
- Reset mid-burst drops the transaction locally. The interconnect must also be reset (same resetn).

Optional Feature:
- CRITICAL_WORD_FIRST_EN defined:
  - arburst=WRAP; araddr={miss_addr[31:2],2'b00}.
  - Counter starts at miss_addr[4:2] and wraps, so crit_valid fires 1 cycle after the first beat.
- Undefined:
  - arburst=INCR; araddr=line base; counter starts at 0.
  - crit_valid fires 1 cycle after beat miss_addr[4:2].
- WRITE, fill_din_all ordering and refill_done timing are identical in both builds.

Decomposition:
- Shared package cache_pkg holds:
  - refill_state_e enum.
  - Constants LINE_WORDS=8, AXI_BURST_INCR, AXI_BURST_WRAP, AXI_RESP_OKAY, OFFSET_BITS=5.
- One natural sub-module, refill_line_buffer: 8x32 register file with indexed write and flat 256-bit read.

Test Plan:
- Miss 0x0000_1234, zero-wait slave returning words 0xA0..0xA7:
  - araddr=0x1220 (INCR); crit_data=0xA5 one cycle after the 6th beat.
  - fill_waddr=0x088; fill_din_all word0=0xA0 .. word7=0xA7; refill_done one cycle after fill_we.
- Same miss with CRITICAL_WORD_FIRST_EN:
  - araddr=0x1234, arburst=2'b10; beats ordered words 5,6,7,0..4.
  - crit_valid one cycle after the first beat; fill_din_all identical to the previous case.
- arready delayed 5 cycles and random rvalid gaps:
  - araddr/arvalid stay stable; line contents are unchanged versus the zero-wait run.
- Beat 3 returns rresp=2'b10: refill_err=1 through DONE; line still written; cleared on the next miss.
- Early rlast on beat 4: WRITE entered after beat 4, refill_err=1, refill_done pulses.
- resetn low during RECV beat 2: all outputs 0 within the same cycle; a new miss afterwards completes normally.
